simon_sequencer: RTL and testbench
==================================

SIMON_SEQUENCER -- requirements
Module: simon_sequencer

Interface
REQ-001 SHALL have parameter MAX_LEN, 16, maximum sequence length; reaching it wins the game.
REQ-002 SHALL have parameter ON_CYCLES, 25_000_000, cycles each playback step stays highlighted.
REQ-003 SHALL have parameter OFF_CYCLES, 12_500_000, blank cycles after each playback step.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, 250_000_000, maximum wait per player key.
REQ-005 SHALL have port clock  input  1  single clock for the whole block.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port start  input  1  one-cycle pulse that begins a new game.
REQ-008 SHALL have port key_valid  input  1  one-cycle pulse meaning the player pressed a direction.
REQ-009 SHALL have port key_dir  input  2  pressed direction; valid only with key_valid.
REQ-010 SHALL have port show_valid  output  1  one-cycle pulse telling the drawer to highlight show_dir.
REQ-011 SHALL have port show_dir  output  2  direction to highlight: 00 up, 01 down, 10 right, 11 left.
REQ-012 SHALL have port show_clear  output  1  one-cycle pulse telling the drawer to restore all squares to rest colour.
REQ-013 SHALL have port player_turn  output  1  high while player input is accepted.
REQ-014 SHALL have port level  output  5  current sequence length.
REQ-015 SHALL have port game_over  output  1  high after a wrong key or a timeout.
REQ-016 SHALL have port win  output  1  high after MAX_LEN steps are completed.

Function
REQ-017 SHALL implement the states IDLE, GEN, PLAY_ON, PLAY_OFF, WAIT_INPUT, FAIL and WIN.
REQ-018 SHALL store the sequence as a MAX_LEN x 2-bit register array, plus an index idx and a length len, both $clog2(MAX_LEN+1) bits wide.
REQ-019 SHALL run a 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1) that advances every cycle in every state and never reaches zero.
REQ-020 SHALL accept start only in IDLE, FAIL or WIN: on start, len<=0, game_over<=0, win<=0, next state GEN; start in any other state is ignored.
REQ-021 SHALL spend exactly one cycle in GEN: seq[len]<=lfsr[1:0], len<=len+1, idx<=0, then go to PLAY_ON.
REQ-022 In PLAY_ON, SHALL assert show_valid with show_dir=seq[idx] only in the first cycle, and stay exactly ON_CYCLES cycles.
REQ-023 SHALL pulse show_clear on the PLAY_ON to PLAY_OFF transition cycle, then stay in PLAY_OFF exactly OFF_CYCLES cycles.
REQ-024 On leaving PLAY_OFF: if idx==len-1, idx<=0 and go to WAIT_INPUT; otherwise idx<=idx+1 and go to PLAY_ON.
REQ-025 In WAIT_INPUT, SHALL hold player_turn=1 and use a single down-counter, reloaded with TIMEOUT_CYCLES-1 on entry and on every accepted key.
REQ-026 On key_valid in WAIT_INPUT, SHALL echo the key as show_valid/show_dir=key_dir in the next cycle.
REQ-027 On key_valid with a match and idx<len-1: idx<=idx+1.
REQ-028 On key_valid with a match and idx==len-1: go to WIN if len==MAX_LEN, else to GEN.
REQ-029 On key_valid with a mismatch: go to FAIL.
REQ-030 On counter expiry in WAIT_INPUT with no key: go to FAIL.
REQ-031 SHALL ignore key_valid outside WAIT_INPUT.
REQ-032 If key_valid and start coincide in WAIT_INPUT, SHALL process the key and drop start.
REQ-033 In FAIL, SHALL hold game_over=1 and pulse show_clear once on entry; in WIN, SHALL hold win=1 and pulse show_clear once on entry.
REQ-034 level SHALL equal len at all times.
REQ-035 SHALL register all outputs, with no combinational path from inputs to outputs.
REQ-036 The timer SHALL be one down-counter shared across states, with width $clog2 of the largest cycle parameter.

Reset
REQ-037 When reset is high on a clock edge, from any state including mid-playback, the block SHALL go to IDLE with len=0, idx=0, timer=0, LFSR=16'hACE1.
REQ-038 Reset SHALL drive all outputs to 0, and SHALL take priority over start and key_valid.
REQ-039 Reset SHALL leave sequence array contents unspecified, because len=0 masks them.

Structure
REQ-040 A shared include simon_defs.vh SHALL hold the direction codes DIR_UP/DOWN/RIGHT/LEFT and the state encodings, for common use with the drawing FSM.
REQ-041 The LFSR SHALL be the sub-module simon_lfsr (ports clock, reset, value[15:0]).
REQ-042 The timer and sequence array SHALL stay inline.

Verification (bench parameters: MAX_LEN=3, ON_CYCLES=4, OFF_CYCLES=2, TIMEOUT_CYCLES=20)
REQ-043 Reset then start -> GEN for 1 cycle; show_valid pulse with show_dir=seq[0]; show_clear exactly 4 cycles later; player_turn high 2 cycles after that; level=1.
REQ-044 Reply with correct keys on every level -> levels 1,2,3 play 1,2,3 steps; after the final correct key, win=1, show_clear pulses once, level=3.
REQ-045 At level 2, first key correct and second key wrong -> game_over=1 the cycle after the wrong key; a later start clears it and level returns to 1.
REQ-046 No key for 20 cycles in WAIT_INPUT -> game_over=1; key_valid during PLAY_ON/PLAY_OFF -> no state or idx change.
REQ-047 Reset asserted in the middle of PLAY_ON -> IDLE next cycle with all outputs 0; start in the same cycle as reset -> block stays in IDLE.
REQ-048 start pulsed during PLAY_OFF or WAIT_INPUT -> ignored; the sequence and level are unchanged.

Source files
------------

// File: rtl/simon_sequencer_pkg.sv
// Shared definitions for the Simon sequencer and the drawing FSM: direction codes,
// state encodings, LFSR seed/step and small elaboration helpers.
package simon_sequencer_pkg;

  localparam logic [1:0] DirUp    = 2'b00;
  localparam logic [1:0] DirDown  = 2'b01;
  localparam logic [1:0] DirRight = 2'b10;
  localparam logic [1:0] DirLeft  = 2'b11;

  typedef enum logic [2:0] {
    StIdle      = 3'd0,
    StGen       = 3'd1,
    StPlayOn    = 3'd2,
    StPlayOff   = 3'd3,
    StWaitInput = 3'd4,
    StFail      = 3'd5,
    StWin       = 3'd6
  } state_e;

  localparam logic [15:0] LfsrSeed = 16'hACE1;

  // Fibonacci LFSR, taps 16,14,13,11; the seed is non-zero so zero is never reached.
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/simon_lfsr.sv
// Free-running 16-bit LFSR used as the random source for new sequence steps.
module simon_lfsr
  import simon_sequencer_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  output logic [15:0] value
);

  logic [15:0] value_q, value_d;

  always_comb begin
    value_d = lfsr_step(value_q);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      value_q <= LfsrSeed;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/simon_sequencer.sv
// Simon game sequencer: grows a random direction sequence, plays it back to the drawer
// and checks the player's replies against it, with a per-key timeout.
module simon_sequencer
  import simon_sequencer_pkg::*;
#(
  parameter int unsigned MAX_LEN        = 16,
  parameter int unsigned ON_CYCLES      = 25_000_000,
  parameter int unsigned OFF_CYCLES     = 12_500_000,
  parameter int unsigned TIMEOUT_CYCLES = 250_000_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       key_valid,
  input  logic [1:0] key_dir,
  output logic       show_valid,
  output logic [1:0] show_dir,
  output logic       show_clear,
  output logic       player_turn,
  output logic [4:0] level,
  output logic       game_over,
  output logic       win
);

  localparam int unsigned LenW     = $clog2(MAX_LEN + 1);
  localparam int unsigned TimerMax = max3(ON_CYCLES, OFF_CYCLES, TIMEOUT_CYCLES);
  localparam int unsigned TimerW   = (TimerMax > 1) ? $clog2(TimerMax) : 1;

  localparam logic [LenW-1:0]   LenOne    = LenW'(1);
  localparam logic [LenW-1:0]   MaxLen    = LenW'(MAX_LEN);
  localparam logic [TimerW-1:0] TimerOne  = TimerW'(1);
  localparam logic [TimerW-1:0] OnLoad    = TimerW'(ON_CYCLES - 1);
  localparam logic [TimerW-1:0] OffLoad   = TimerW'(OFF_CYCLES - 1);
  localparam logic [TimerW-1:0] WaitLoad  = TimerW'(TIMEOUT_CYCLES - 1);

  state_e            state_q, state_d;
  logic [LenW-1:0]   len_q, len_d;
  logic [LenW-1:0]   idx_q, idx_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [1:0]        seq_q [MAX_LEN];
  logic [1:0]        seq_d [MAX_LEN];

  logic       show_valid_q, show_valid_d;
  logic [1:0] show_dir_q, show_dir_d;
  logic       show_clear_q, show_clear_d;
  logic       player_turn_q, player_turn_d;
  logic       game_over_q, game_over_d;
  logic       win_q, win_d;

  logic [15:0] lfsr_value;
  logic        unused_lfsr;
  logic [1:0]  cur_dir, nxt_dir, first_dir;
  logic [LenW-1:0] last_idx;

  simon_lfsr u_lfsr (
    .clock (clock),
    .reset (reset),
    .value (lfsr_value)
  );

  assign unused_lfsr = ^lfsr_value[15:2];
  assign last_idx    = len_q - LenOne;

  // Array reads by loop so the index width never has to match the array depth.
  always_comb begin
    cur_dir = 2'b00;
    nxt_dir = 2'b00;
    for (int i = 0; i < int'(MAX_LEN); i++) begin
      if (idx_q == LenW'(i)) cur_dir = seq_q[i];
      if ((idx_q + LenOne) == LenW'(i)) nxt_dir = seq_q[i];
    end
    // On the very first GEN, seq[0] is being written this cycle.
    first_dir = (len_q == '0) ? lfsr_value[1:0] : seq_q[0];
  end

  always_comb begin
    state_d       = state_q;
    len_d         = len_q;
    idx_d         = idx_q;
    timer_d       = (timer_q != '0) ? (timer_q - TimerOne) : '0;
    seq_d         = seq_q;
    show_valid_d  = 1'b0;
    show_dir_d    = show_dir_q;
    show_clear_d  = 1'b0;
    player_turn_d = 1'b0;
    game_over_d   = game_over_q;
    win_d         = win_q;

    unique case (state_q)
      StIdle, StFail, StWin: begin
        if (start) begin
          state_d     = StGen;
          len_d       = '0;
          game_over_d = 1'b0;
          win_d       = 1'b0;
        end
      end
      StGen: begin
        for (int i = 0; i < int'(MAX_LEN); i++) begin
          if (len_q == LenW'(i)) seq_d[i] = lfsr_value[1:0];
        end
        len_d        = len_q + LenOne;
        idx_d        = '0;
        state_d      = StPlayOn;
        timer_d      = OnLoad;
        show_valid_d = 1'b1;
        show_dir_d   = first_dir;
      end
      StPlayOn: begin
        if (timer_q == '0) begin
          state_d      = StPlayOff;
          timer_d      = OffLoad;
          show_clear_d = 1'b1;
        end
      end
      StPlayOff: begin
        if (timer_q == '0) begin
          if (idx_q == last_idx) begin
            idx_d         = '0;
            state_d       = StWaitInput;
            timer_d       = WaitLoad;
            player_turn_d = 1'b1;
          end else begin
            idx_d        = idx_q + LenOne;
            state_d      = StPlayOn;
            timer_d      = OnLoad;
            show_valid_d = 1'b1;
            show_dir_d   = nxt_dir;
          end
        end
      end
      StWaitInput: begin
        player_turn_d = 1'b1;
        if (key_valid) begin
          show_valid_d = 1'b1;
          show_dir_d   = key_dir;
          if (key_dir == cur_dir) begin
            if (idx_q == last_idx) begin
              player_turn_d = 1'b0;
              if (len_q == MaxLen) begin
                state_d      = StWin;
                win_d        = 1'b1;
                show_clear_d = 1'b1;
              end else begin
                state_d = StGen;
              end
            end else begin
              idx_d   = idx_q + LenOne;
              timer_d = WaitLoad;
            end
          end else begin
            state_d       = StFail;
            game_over_d   = 1'b1;
            show_clear_d  = 1'b1;
            player_turn_d = 1'b0;
          end
        end else if (timer_q == '0) begin
          state_d       = StFail;
          game_over_d   = 1'b1;
          show_clear_d  = 1'b1;
          player_turn_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= StIdle;
      len_q         <= '0;
      idx_q         <= '0;
      timer_q       <= '0;
      show_valid_q  <= 1'b0;
      show_dir_q    <= 2'b00;
      show_clear_q  <= 1'b0;
      player_turn_q <= 1'b0;
      game_over_q   <= 1'b0;
      win_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      idx_q         <= idx_d;
      timer_q       <= timer_d;
      show_valid_q  <= show_valid_d;
      show_dir_q    <= show_dir_d;
      show_clear_q  <= show_clear_d;
      player_turn_q <= player_turn_d;
      game_over_q   <= game_over_d;
      win_q         <= win_d;
    end
  end

  // Contents are masked by len after reset, so the array needs no reset.
  always_ff @(posedge clock) begin
    seq_q <= seq_d;
  end

  assign show_valid  = show_valid_q;
  assign show_dir    = show_dir_q;
  assign show_clear  = show_clear_q;
  assign player_turn = player_turn_q;
  assign level       = 5'(len_q);
  assign game_over   = game_over_q;
  assign win         = win_q;

endmodule

// File: tb/tb_simon_sequencer.sv
// Directed bench for simon_sequencer with short timing parameters and an LFSR reference.
module tb_simon_sequencer;

  logic       clock;
  logic       reset;
  logic       start;
  logic       key_valid;
  logic [1:0] key_dir;
  logic       show_valid;
  logic [1:0] show_dir;
  logic       show_clear;
  logic       player_turn;
  logic [4:0] level;
  logic       game_over;
  logic       win;

  int total = 0;
  int bad   = 0;

  logic [15:0] m_lfsr;
  logic [1:0]  exp_seq [3];

  simon_sequencer #(
    .MAX_LEN        (3),
    .ON_CYCLES      (4),
    .OFF_CYCLES     (2),
    .TIMEOUT_CYCLES (20)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .key_valid   (key_valid),
    .key_dir     (key_dir),
    .show_valid  (show_valid),
    .show_dir    (show_dir),
    .show_clear  (show_clear),
    .player_turn (player_turn),
    .level       (level),
    .game_over   (game_over),
    .win         (win)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference LFSR: taps 16,14,13,11, seed ACE1, steps every cycle.
  always @(posedge clock) begin
    if (reset) m_lfsr <= 16'hACE1;
    else       m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, 8'(show_valid), 8'h0);
    chk({tag, "_dir"}, 8'(show_dir), 8'h0);
    chk({tag, "_clear"}, 8'(show_clear), 8'h0);
    chk({tag, "_turn"}, 8'(player_turn), 8'h0);
    chk({tag, "_level"}, 8'(level), 8'h0);
    chk({tag, "_over"}, 8'(game_over), 8'h0);
    chk({tag, "_win"}, 8'(win), 8'h0);
  endtask

  // Called while the DUT is in GEN; ends on the first WAIT_INPUT cycle.
  task automatic run_playback(input int n);
    exp_seq[n-1] = m_lfsr[1:0];
    tick();
    for (int i = 0; i < n; i++) begin
      chk("pb_valid", 8'(show_valid), 8'h1);
      chk("pb_dir", 8'(show_dir), 8'(exp_seq[i]));
      repeat (4) tick();
      chk("pb_clear", 8'(show_clear), 8'h1);
      repeat (2) tick();
    end
    chk("pb_turn", 8'(player_turn), 8'h1);
    chk("pb_level", 8'(n), 8'(level));
  endtask

  task automatic press(input logic [1:0] d);
    key_valid = 1'b1;
    key_dir   = d;
    tick();
    key_valid = 1'b0;
    chk("echo_valid", 8'(show_valid), 8'h1);
    chk("echo_dir", 8'(show_dir), 8'(d));
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    key_valid = 1'b0;
    key_dir   = 2'b00;
    tick();
    tick();
    chk_all_zero("rst");
    reset = 1'b0;

    // Full game to a win.
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("gen_level", 8'(level), 8'h0);
    chk("gen_valid", 8'(show_valid), 8'h0);
    run_playback(1);
    press(exp_seq[0]);
    run_playback(2);
    press(exp_seq[0]);
    chk("mid_turn", 8'(player_turn), 8'h1);
    press(exp_seq[1]);
    run_playback(3);
    press(exp_seq[0]);
    press(exp_seq[1]);
    press(exp_seq[2]);
    chk("win", 8'(win), 8'h1);
    chk("win_clear", 8'(show_clear), 8'h1);
    chk("win_level", 8'(level), 8'h3);
    chk("win_turn", 8'(player_turn), 8'h0);
    tick();
    chk("win_clear_once", 8'(show_clear), 8'h0);
    chk("win_hold", 8'(win), 8'h1);

    // Wrong second key at level 2.
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_win", 8'(win), 8'h0);
    chk("restart_level", 8'(level), 8'h0);
    run_playback(1);
    press(exp_seq[0]);
    run_playback(2);
    press(exp_seq[0]);
    chk("l2_over_early", 8'(game_over), 8'h0);
    press(exp_seq[1] ^ 2'b11);
    chk("wrong_over", 8'(game_over), 8'h1);
    chk("wrong_clear", 8'(show_clear), 8'h1);
    chk("wrong_turn", 8'(player_turn), 8'h0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_over", 8'(game_over), 8'h0);
    run_playback(1);

    // Timeout with no key.
    repeat (19) tick();
    chk("to_before_over", 8'(game_over), 8'h0);
    chk("to_before_turn", 8'(player_turn), 8'h1);
    tick();
    chk("to_over", 8'(game_over), 8'h1);
    chk("to_turn", 8'(player_turn), 8'h0);

    // Keys and start during playback are ignored.
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_seq[0] = m_lfsr[1:0];
    tick();
    chk("ign_valid", 8'(show_valid), 8'h1);
    chk("ign_dir", 8'(show_dir), 8'(exp_seq[0]));
    key_valid = 1'b1;
    key_dir   = exp_seq[0] ^ 2'b01;
    tick();
    key_valid = 1'b0;
    chk("ign_on_echo", 8'(show_valid), 8'h0);
    repeat (3) tick();
    chk("ign_clear", 8'(show_clear), 8'h1);
    start     = 1'b1;
    key_valid = 1'b1;
    key_dir   = exp_seq[0] ^ 2'b10;
    tick();
    start     = 1'b0;
    key_valid = 1'b0;
    chk("ign_off_level", 8'(level), 8'h1);
    chk("ign_off_echo", 8'(show_valid), 8'h0);
    tick();
    chk("ign_wait_turn", 8'(player_turn), 8'h1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_wait_turn", 8'(player_turn), 8'h1);
    chk("start_wait_level", 8'(level), 8'h1);

    // Key and start together in WAIT_INPUT: the key wins.
    start     = 1'b1;
    key_valid = 1'b1;
    key_dir   = exp_seq[0];
    tick();
    start     = 1'b0;
    key_valid = 1'b0;
    chk("ks_echo", 8'(show_valid), 8'h1);
    chk("ks_level", 8'(level), 8'h1);
    run_playback(2);
    press(exp_seq[0]);
    press(exp_seq[1]);

    // Reset mid-PLAY_ON, together with start.
    tick();
    chk("pre_rst_valid", 8'(show_valid), 8'h1);
    chk("pre_rst_level", 8'(level), 8'h3);
    tick();
    reset = 1'b1;
    start = 1'b1;
    tick();
    reset = 1'b0;
    start = 1'b0;
    chk_all_zero("midrst");
    tick();
    chk("idle1_level", 8'(level), 8'h0);
    tick();
    chk("idle2_valid", 8'(show_valid), 8'h0);
    chk("idle2_level", 8'(level), 8'h0);

    // Fresh game after reset uses the reseeded LFSR.
    start = 1'b1;
    tick();
    start = 1'b0;
    run_playback(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
